reg_table: RTL and testbench

- 128-entry x 128-bit register file (RegTable) for the SPU pipeline.
- Supplies the three source operands ra/rb/rc to the RF/FWD stage with one cycle of read latency.
- Accepts the writeback port (rt_wb, rt_addr_wb, reg_write_wb) driven by the execution units.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards against in-flight instructions.

---
 rtl/reg_table.sv | 81 ++++++++
 tb/tb_reg_table.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_table.sv
// SPU register file: 128 x 128-bit, three registered read ports with write-through
// bypass, one writeback port, and a per-register pending-write scoreboard.
module reg_table #(
  parameter int NUM_REGS = 128,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:ADDR_W-1] ra_addr,
  input  logic [0:ADDR_W-1] rb_addr,
  input  logic [0:ADDR_W-1] rc_addr,
  input  logic              ra_used,
  input  logic              rb_used,
  input  logic              rc_used,
  input  logic              issue,
  input  logic [0:ADDR_W-1] issue_rt_addr,
  input  logic              issue_reg_write,
  input  logic [0:DATA_W-1] rt_wb,
  input  logic [0:ADDR_W-1] rt_addr_wb,
  input  logic              reg_write_wb,
  output logic [0:DATA_W-1] ra,
  output logic [0:DATA_W-1] rb,
  output logic [0:DATA_W-1] rc,
  output logic              hazard,
  output logic [0:NUM_REGS-1] pending
);

  logic [0:DATA_W-1]   regs_q [NUM_REGS];
  logic [0:DATA_W-1]   ra_q, rb_q, rc_q;
  logic [0:DATA_W-1]   ra_d, rb_d, rc_d;
  logic [0:NUM_REGS-1] pending_q, pending_d;
  logic                byp_a, byp_b, byp_c;

  // A writeback landing this cycle forwards straight to the read ports.
  always_comb begin
    byp_a = reg_write_wb && (rt_addr_wb == ra_addr);
    byp_b = reg_write_wb && (rt_addr_wb == rb_addr);
    byp_c = reg_write_wb && (rt_addr_wb == rc_addr);
    ra_d  = byp_a ? rt_wb : regs_q[ra_addr];
    rb_d  = byp_b ? rt_wb : regs_q[rb_addr];
    rc_d  = byp_c ? rt_wb : regs_q[rc_addr];
  end

  // Set is applied after clear so a younger producer keeps the bit.
  always_comb begin
    pending_d = pending_q;
    if (reg_write_wb)
      pending_d[rt_addr_wb] = 1'b0;
    if (issue && issue_reg_write)
      pending_d[issue_rt_addr] = 1'b1;
  end

  assign hazard = (ra_used && pending_q[ra_addr] && !byp_a) ||
                  (rb_used && pending_q[rb_addr] && !byp_b) ||
                  (rc_used && pending_q[rc_addr] && !byp_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      pending_q <= '0;
    end else begin
      if (reg_write_wb)
        regs_q[rt_addr_wb] <= rt_wb;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rc_q      <= rc_d;
      pending_q <= pending_d;
    end
  end

  assign ra      = ra_q;
  assign rb      = rb_q;
  assign rc      = rc_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_reg_table.sv
// Scoreboard bench for reg_table: stimulus queues expectations tagged with the
// cycle they are due; a negedge monitor pops and compares them.
module tb_reg_table;

  logic         clk = 1'b0;
  logic         reset;
  logic [0:6]   ra_addr, rb_addr, rc_addr;
  logic         ra_used, rb_used, rc_used;
  logic         issue;
  logic [0:6]   issue_rt_addr;
  logic         issue_reg_write;
  logic [0:127] rt_wb;
  logic [0:6]   rt_addr_wb;
  logic         reg_write_wb;
  logic [0:127] ra, rb, rc;
  logic         hazard;
  logic [0:127] pending;

  reg_table dut (
    .clk(clk), .reset(reset),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
    .ra_used(ra_used), .rb_used(rb_used), .rc_used(rc_used),
    .issue(issue), .issue_rt_addr(issue_rt_addr), .issue_reg_write(issue_reg_write),
    .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb),
    .ra(ra), .rb(rb), .rc(rc), .hazard(hazard), .pending(pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = ra/rb/rc, 1 = hazard, 2 = one pending bit, 3 = whole pending vector
  typedef struct {
    int           due;
    int           kind;
    logic [0:127] a, b, c;
    int           idx;
    logic         bit_v;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  int    n_cmp = 0;
  int    n_err = 0;

  localparam logic [0:127] V10  = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [0:127] VA   = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
  localparam logic [0:127] VD   = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [0:127] V3   = 128'h3333_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [0:127] V7   = 128'h7777_7777_0000_0000_FFFF_FFFF_1234_5678;
  localparam logic [0:127] V9   = 128'h9999_8888_7777_6666_5555_4444_3333_2222;
  localparam logic [0:127] V0   = 128'h0000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [0:127] V127 = 128'h8000_0000_0000_0000_0000_0000_0000_007F;

  task automatic push(input string name, input int due, input int kind,
                      input logic [0:127] a, input logic [0:127] b, input logic [0:127] c,
                      input int idx, input logic bit_v);
    exp_t e;
    e.due = due; e.kind = kind; e.a = a; e.b = b; e.c = c; e.idx = idx; e.bit_v = bit_v;
    q.push_back(e);
    qn.push_back(name);
  endtask

  task automatic exp_ops(input string name, input int due,
                         input logic [0:127] a, input logic [0:127] b, input logic [0:127] c);
    push(name, due, 0, a, b, c, 0, 1'b0);
  endtask

  task automatic exp_haz(input string name, input logic v);
    push(name, cyc, 1, '0, '0, '0, 0, v);
  endtask

  task automatic exp_pend(input string name, input int idx, input logic v);
    push(name, cyc, 2, '0, '0, '0, idx, v);
  endtask

  task automatic fail_line(input string name, input string what,
                           input logic [0:127] got, input logic [0:127] want);
    n_err++;
    $display("FAIL %s %s: got %h want %h", name, what, got, want);
  endtask

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due == cyc) begin
        case (q[i].kind)
          0: begin
            n_cmp += 3;
            if (ra !== q[i].a) fail_line(qn[i], "ra", ra, q[i].a);
            if (rb !== q[i].b) fail_line(qn[i], "rb", rb, q[i].b);
            if (rc !== q[i].c) fail_line(qn[i], "rc", rc, q[i].c);
          end
          1: begin
            n_cmp++;
            if (hazard !== q[i].bit_v) begin
              n_err++;
              $display("FAIL %s hazard: got %b want %b", qn[i], hazard, q[i].bit_v);
            end
          end
          2: begin
            n_cmp++;
            if (pending[q[i].idx] !== q[i].bit_v) begin
              n_err++;
              $display("FAIL %s pending[%0d]: got %b want %b", qn[i], q[i].idx,
                       pending[q[i].idx], q[i].bit_v);
            end
          end
          default: begin
            n_cmp++;
            if (pending !== q[i].a) fail_line(qn[i], "pending", pending, q[i].a);
          end
        endcase
        q.delete(i);
        qn.delete(i);
      end else if (q[i].due < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s: expectation missed at cycle %0d", qn[i], q[i].due);
        q.delete(i);
        qn.delete(i);
      end
    end
  end

  // Advance to just after the next rising edge and return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    ra_addr = '0; rb_addr = '0; rc_addr = '0;
    ra_used = 1'b0; rb_used = 1'b0; rc_used = 1'b0;
    issue = 1'b0; issue_rt_addr = '0; issue_reg_write = 1'b0;
    reg_write_wb = 1'b0; rt_addr_wb = '0; rt_wb = '0;
  endtask

  task automatic wb(input logic [0:6] addr, input logic [0:127] data);
    reg_write_wb = 1'b1; rt_addr_wb = addr; rt_wb = data;
  endtask

  initial begin
    reset = 1'b1;
    ra_addr = '0; rb_addr = '0; rc_addr = '0;
    ra_used = 1'b0; rb_used = 1'b0; rc_used = 1'b0;
    issue = 1'b0; issue_rt_addr = '0; issue_reg_write = 1'b0;
    reg_write_wb = 1'b0; rt_addr_wb = '0; rt_wb = '0;

    tick();
    exp_ops("reset_ops", cyc, '0, '0, '0);
    push("reset_pend", cyc, 3, '0, '0, '0, 0, 1'b0);
    tick();
    reset = 1'b0;

    // async reset mid-cycle with data and pending state present
    tick(); wb(7'd5, VD);
    tick(); ra_addr = 7'd5; issue = 1'b1; issue_rt_addr = 7'd12; issue_reg_write = 1'b1;
    exp_ops("pre_reset_read", cyc + 1, VD, '0, '0);
    tick(); ra_addr = 7'd5;
    exp_pend("pre_reset_pend12", 12, 1'b1);
    tick(); ra_addr = 7'd5;
    #2 reset = 1'b1;
    exp_ops("async_reset_ops", cyc, '0, '0, '0);
    push("async_reset_pend", cyc, 3, '0, '0, '0, 0, 1'b0);
    tick();
    reset = 1'b0;
    ra_addr = 7'd5;
    exp_ops("post_reset_read5", cyc + 1, '0, '0, '0);

    // write then read with one-cycle latency
    tick(); wb(7'd10, V10);
    tick(); ra_addr = 7'd10;
    exp_ops("write_read10", cyc + 1, V10, '0, '0);

    // same-cycle bypass onto all three ports, then plain read of distinct regs
    tick(); wb(7'd20, VA); ra_addr = 7'd20; rb_addr = 7'd20; rc_addr = 7'd20;
    exp_ops("bypass20", cyc + 1, VA, VA, VA);
    tick(); ra_addr = 7'd20; rb_addr = 7'd10; rc_addr = 7'd0;
    exp_ops("read_mix", cyc + 1, VA, V10, '0);

    // scoreboard and hazard
    tick(); issue = 1'b1; issue_rt_addr = 7'd3; issue_reg_write = 1'b1;
    tick(); exp_pend("pend3_set", 3, 1'b1);
    ra_addr = 7'd3; ra_used = 1'b1;
    exp_haz("haz_ra_used", 1'b1);
    tick(); ra_addr = 7'd3; ra_used = 1'b0; rb_addr = 7'd4; rb_used = 1'b1;
    exp_haz("haz_ra_unused", 1'b0);
    tick(); rc_addr = 7'd3; rc_used = 1'b1;
    exp_haz("haz_rc_used", 1'b1);
    tick(); rb_addr = 7'd3; rb_used = 1'b1;
    exp_haz("haz_rb_used", 1'b1);
    tick(); ra_addr = 7'd3; ra_used = 1'b1; wb(7'd3, V3);
    exp_haz("haz_wb_same_cycle", 1'b0);
    exp_ops("wb3_bypass", cyc + 1, V3, '0, '0);
    tick(); ra_addr = 7'd3; ra_used = 1'b1;
    exp_pend("pend3_clear", 3, 1'b0);
    exp_haz("haz_after_clear", 1'b0);

    // simultaneous set and clear on reg 7
    tick(); issue = 1'b1; issue_rt_addr = 7'd7; issue_reg_write = 1'b1; wb(7'd7, V7);
    tick(); exp_pend("pend7_set_wins", 7, 1'b1);
    ra_addr = 7'd7; ra_used = 1'b1;
    exp_haz("haz7", 1'b1);
    exp_ops("read7", cyc + 1, V7, '0, '0);

    // issue without register write
    tick(); issue = 1'b1; issue_rt_addr = 7'd9; issue_reg_write = 1'b0;
    tick(); exp_pend("pend9_nowrite", 9, 1'b0);
    ra_addr = 7'd9; ra_used = 1'b1;
    exp_haz("haz9", 1'b0);

    // untracked writeback to reg 9
    tick(); wb(7'd9, V9);
    tick(); exp_pend("pend9_untracked", 9, 1'b0);
    ra_addr = 7'd9;
    exp_ops("read9", cyc + 1, V9, '0, '0);

    // address extremes 0 and 127
    tick(); wb(7'd0, V0);
    tick(); wb(7'd127, V127); ra_addr = 7'd0; rb_addr = 7'd127; rc_addr = 7'd127;
    exp_ops("edges_0_127", cyc + 1, V0, V127, V127);
    tick(); ra_addr = 7'd127; rb_addr = 7'd0; rc_addr = 7'd20;
    exp_ops("edges_reread", cyc + 1, V127, V0, VA);

    for (int k = 0; k < 4; k++) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
